rob_commit_ctrl: RTL

In-order retirement controller that sequences the `x` register file's rename/commit ports. It allocates reorder tags at issue and marks destination registers as pending through the regfile dependency port. It collects out-of-order results, then retires one entry per cycle in program order through the regfile write port. On a mispredicted entry it performs a one-cycle dependency flush.

---
 rtl/rob_commit_ctrl_if.sv | 42 ++++
 rtl/rob_commit_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl_if.sv
// Issue, result and regfile ports of the retirement controller.
// master = issue/execute/regfile side, slave = controller.
interface rob_commit_ctrl_if;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic        alloc_ready;
   logic [4:0]  alloc_tag;
   logic        result_valid;
   logic [4:0]  result_tag;
   logic [31:0] result_val;
   logic        result_redirect;
   logic        rf_write_en;
   logic [4:0]  rf_write_id;
   logic [4:0]  rf_write_dependency;
   logic [31:0] rf_write_val;
   logic        rf_dependency_set_en;
   logic [4:0]  rf_dependency_reg;
   logic [4:0]  rf_dependency_dependency;
   logic        rf_dependency_rst;
   logic        flush;
   logic [5:0]  count;

   modport master (
      output alloc_valid, alloc_rd,
      output result_valid, result_tag, result_val, result_redirect,
      input  alloc_ready, alloc_tag,
      input  rf_write_en, rf_write_id, rf_write_dependency, rf_write_val,
      input  rf_dependency_set_en, rf_dependency_reg,
      input  rf_dependency_dependency, rf_dependency_rst,
      input  flush, count
   );

   modport slave (
      input  alloc_valid, alloc_rd,
      input  result_valid, result_tag, result_val, result_redirect,
      output alloc_ready, alloc_tag,
      output rf_write_en, rf_write_id, rf_write_dependency, rf_write_val,
      output rf_dependency_set_en, rf_dependency_reg,
      output rf_dependency_dependency, rf_dependency_rst,
      output flush, count
   );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retirement controller: allocates reorder tags, collects
// out-of-order results, retires in order, one-cycle flush on redirect.
module rob_commit_ctrl #(
   parameter int DEPTH = 32
) (
   input logic              clk,
   input logic              rst,
   rob_commit_ctrl_if.slave io
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [DEPTH-1:0]  ready_q, ready_d;
   logic [DEPTH-1:0]  redir_q, redir_d;
   logic [4:0]        rd_q  [DEPTH];
   logic [4:0]        rd_d  [DEPTH];
   logic [31:0]       val_q [DEPTH];
   logic [31:0]       val_d [DEPTH];
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [5:0]        count_q, count_d;

   logic              commit;
   logic              redir_commit;
   logic              alloc_fire;
   logic              res_hit;
   logic [PW-1:0]     res_idx;

   assign res_idx = io.result_tag[PW-1:0];
   assign res_hit = io.result_valid && ({1'b0, io.result_tag} < 6'(DEPTH));

   assign io.alloc_tag                = 5'(tail_q);
   assign io.rf_dependency_reg        = io.alloc_rd;
   assign io.rf_dependency_dependency = 5'(tail_q);
   assign io.count                    = count_q;

   // Next-state, entry updates and port outputs for RUN / FLUSH.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      ready_d  = ready_q;
      redir_d  = redir_q;
      rd_d     = rd_q;
      val_d    = val_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      commit       = 1'b0;
      redir_commit = 1'b0;
      alloc_fire   = 1'b0;
      io.alloc_ready          = 1'b0;
      io.rf_write_en          = 1'b0;
      io.rf_write_id          = '0;
      io.rf_write_dependency  = '0;
      io.rf_write_val         = '0;
      io.rf_dependency_set_en = 1'b0;
      io.rf_dependency_rst    = 1'b0;
      io.flush                = 1'b0;
      unique case (state_q)
         RUN: begin
            commit       = busy_q[head_q] && ready_q[head_q];
            redir_commit = commit && redir_q[head_q];
            // No bypass of a same-cycle commit into a full buffer.
            io.alloc_ready = (count_q < 6'(DEPTH)) && !redir_commit;
            alloc_fire     = io.alloc_valid && io.alloc_ready;
            io.rf_dependency_set_en = alloc_fire && (io.alloc_rd != 5'd0);
            if (commit) begin
               io.rf_write_en         = rd_q[head_q] != 5'd0;
               io.rf_write_id         = rd_q[head_q];
               io.rf_write_dependency = 5'(head_q);
               io.rf_write_val        = val_q[head_q];
            end
            if (alloc_fire) begin
               busy_d[tail_q]  = 1'b1;
               ready_d[tail_q] = 1'b0;
               redir_d[tail_q] = 1'b0;
               rd_d[tail_q]    = io.alloc_rd;
               tail_d          = tail_q + 1'b1;
            end
            // Only in-flight entries accept results; busy is pre-edge.
            if (res_hit && busy_q[res_idx]) begin
               ready_d[res_idx] = 1'b1;
               val_d[res_idx]   = io.result_val;
               redir_d[res_idx] = io.result_redirect;
            end
            if (commit) begin
               busy_d[head_q] = 1'b0;
               head_d         = head_q + 1'b1;
            end
            count_d = count_q + 6'(alloc_fire) - 6'(commit);
            if (redir_commit) state_d = FLUSH;
         end
         FLUSH: begin
            io.rf_dependency_rst = 1'b1;
            io.flush             = 1'b1;
            busy_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         busy_q  <= '0;
         ready_q <= '0;
         redir_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         redir_q <= redir_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry payload; only observed through busy entries.
   always_ff @(posedge clk) begin
      rd_q  <= rd_d;
      val_q <= val_d;
   end
endmodule
